// File: rtl/mfp_uart_transmitter.sv
// FIFO-buffered UART transmitter: bytes in over valid/ready, 8N1 frames out on tx, LSB first.
// Define MFP_UART_TX_PARITY_EN to insert an even-parity bit (8E1, 11 bit periods per frame).
module mfp_uart_transmitter #(
   parameter int CLOCK_FREQUENCY = 50000000,
   parameter int BAUD_RATE       = 115200,
   parameter int FIFO_DEPTH_LOG2 = 3
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [7:0]                 byte_data,
   input  logic                       byte_valid,
   output logic                       byte_ready,
   output logic                       tx,
   output logic                       busy,
   output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);
   localparam int DIV   = CLOCK_FREQUENCY / BAUD_RATE;
   localparam int CW    = (DIV >= 2) ? $clog2(DIV) : 1;
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int AW    = FIFO_DEPTH_LOG2;

   generate
      if (DIV < 2) begin : g_div_check
         $error("mfp_uart_transmitter: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
      end
   endgenerate

`ifdef MFP_UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state_reg, state_next;
   logic [CW-1:0]   baud_reg, baud_next;
   logic [2:0]      bit_idx_reg, bit_idx_next;
   logic [7:0]      shift_reg, shift_next;
   logic            tx_reg, tx_next;
   logic            busy_reg, busy_next;
   logic [AW:0]     wr_ptr_reg, wr_ptr_next;
   logic [AW:0]     rd_ptr_reg, rd_ptr_next;
   logic [AW:0]     count_reg, count_next;
`ifdef MFP_UART_TX_PARITY_EN
   logic            parity_reg, parity_next;
`endif

   logic [7:0]      mem [0:DEPTH-1];
   logic [7:0]      head;
   logic            full, empty, push, pop, bit_end;

   // Extra pointer bit distinguishes full from empty when the index bits match.
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign push    = byte_valid && !full;
   assign head    = mem[rd_ptr_reg[AW-1:0]];
   assign bit_end = (baud_reg == CW'(DIV - 1));

   assign wr_ptr_next = wr_ptr_reg + (push ? 1'b1 : 1'b0);
   assign rd_ptr_next = rd_ptr_reg + (pop ? 1'b1 : 1'b0);
   assign count_next  = wr_ptr_next - rd_ptr_next;

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr_reg[AW-1:0]] <= byte_data;
      end
   end

   always_comb begin
      state_next   = state_reg;
      bit_idx_next = bit_idx_reg;
      shift_next   = shift_reg;
      pop          = 1'b0;
      baud_next    = (state_reg == IDLE || bit_end) ? '0 : baud_reg + 1'b1;
`ifdef MFP_UART_TX_PARITY_EN
      parity_next  = parity_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               shift_next = head;
               state_next = START;
`ifdef MFP_UART_TX_PARITY_EN
               parity_next = ^head;
`endif
            end
         end
         START: begin
            if (bit_end) begin
               bit_idx_next = '0;
               state_next   = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_next = {1'b0, shift_reg[7:1]};
               if (bit_idx_reg == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end else begin
                  bit_idx_next = bit_idx_reg + 1'b1;
               end
            end
         end
`ifdef MFP_UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_next = STOP;
            end
         end
`endif
         STOP: begin
            // Reload straight into START when more data is queued: no idle gap.
            if (bit_end) begin
               if (!empty) begin
                  pop        = 1'b1;
                  shift_next = head;
                  state_next = START;
`ifdef MFP_UART_TX_PARITY_EN
                  parity_next = ^head;
`endif
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
`ifdef MFP_UART_TX_PARITY_EN
         PARITY:  tx_next = parity_next;
`endif
         default: tx_next = 1'b1;
      endcase

      busy_next = (state_next != IDLE) || (wr_ptr_next != rd_ptr_next);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         baud_reg    <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
         tx_reg      <= 1'b1;
         busy_reg    <= 1'b0;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
`ifdef MFP_UART_TX_PARITY_EN
         parity_reg  <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         baud_reg    <= baud_next;
         bit_idx_reg <= bit_idx_next;
         shift_reg   <= shift_next;
         tx_reg      <= tx_next;
         busy_reg    <= busy_next;
         wr_ptr_reg  <= wr_ptr_next;
         rd_ptr_reg  <= rd_ptr_next;
         count_reg   <= count_next;
`ifdef MFP_UART_TX_PARITY_EN
         parity_reg  <= parity_next;
`endif
      end
   end

   assign byte_ready = !full;
   assign tx         = tx_reg;
   assign busy       = busy_reg;
   assign fifo_count = count_reg;

endmodule
